// File: rtl/rob_pkg.sv
// rtl/rob_pkg.sv - shared widths, opcode codes and entry layout for the reorder buffer
package rob_pkg;

    localparam int ILEN    = 6;
    localparam int RLEN    = 32;
    localparam int ROBSIZE = 16;
    localparam int RBID_W  = 4;

    localparam logic [ILEN-1:0] INST_ADD  = 6'd1;
    localparam logic [ILEN-1:0] INST_ADDI = 6'd2;
    localparam logic [ILEN-1:0] INST_LW   = 6'd10;
    localparam logic [ILEN-1:0] INST_SW   = 6'd14;
    localparam logic [ILEN-1:0] INST_BEQ  = 6'd32;
    localparam logic [ILEN-1:0] INST_BNE  = 6'd33;
    localparam logic [ILEN-1:0] INST_BLT  = 6'd34;
    localparam logic [ILEN-1:0] INST_BGE  = 6'd35;
    localparam logic [ILEN-1:0] INST_BLTU = 6'd36;
    localparam logic [ILEN-1:0] INST_BGEU = 6'd37;
    // JALR sits in the control-flow range (bit 5 set) but is not a branch
    localparam logic [ILEN-1:0] INST_JALR = 6'd40;

    typedef struct packed {
        logic            busy;
        logic            ready;
        logic [ILEN-1:0] insty;
        logic [4:0]      rd;
        logic            is_store;
        logic            pred_jump;
        logic [RLEN-1:0] alt_pc;
        logic [RLEN-1:0] value;
    } rob_entry_t;

    function automatic logic is_jalr(input logic [ILEN-1:0] insty);
        return insty == INST_JALR;
    endfunction

    function automatic logic is_branch(input logic [ILEN-1:0] insty);
        return insty[5] && !is_jalr(insty);
    endfunction

endpackage

// File: rtl/rob.sv
// rtl/rob.sv - reorder buffer: tag allocation, result capture, in-order retire, flush on mispredict
module rob
    import rob_pkg::*;
#(
    parameter int ROB_SIZE = ROBSIZE,
    parameter int IDX_W    = RBID_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             alloc_flag,
    input  logic [ILEN-1:0]  alloc_insty,
    input  logic [4:0]       alloc_rd,
    input  logic             alloc_is_store,
    input  logic             alloc_pred_jump,
    input  logic [31:0]      alloc_alt_pc,
    output logic [IDX_W-1:0] new_ROB_idx,
    output logic             rob_full,
    input  logic [IDX_W-1:0] query_idx1,
    input  logic [IDX_W-1:0] query_idx2,
    output logic             query_ready1,
    output logic             query_ready2,
    output logic [31:0]      query_val1,
    output logic [31:0]      query_val2,
    input  logic             ari_val_flag,
    input  logic [IDX_W-1:0] ari_val_idx,
    input  logic [31:0]      ari_val,
    input  logic             cmp_val_flag,
    input  logic [IDX_W-1:0] cmp_val_idx,
    input  logic [31:0]      cmp_val,
    input  logic             val_flag_LSB,
    input  logic [IDX_W-1:0] val_idx_LSB,
    input  logic [31:0]      val_LSB,
    output logic             commit_flag,
    output logic [IDX_W-1:0] commit_idx,
    output logic [4:0]       commit_rd,
    output logic [31:0]      commit_val,
    output logic             commit_is_store,
    output logic             jp_wrong,
    output logic [31:0]      jp_pc
);

    localparam int CW = IDX_W + 1;

    rob_entry_t       ent [ROB_SIZE];
    logic [IDX_W-1:0] head;
    logic [IDX_W-1:0] tail;
    logic [CW-1:0]    count;

    rob_entry_t       hd;
    logic             do_alloc;
    logic             do_retire;
    logic             hd_jalr;
    logic             hd_branch;
    logic             mispredict;

    logic             wb_flag [3];
    logic [IDX_W-1:0] wb_idx  [3];
    logic [31:0]      wb_val  [3];

    assign wb_flag = '{ari_val_flag, cmp_val_flag, val_flag_LSB};
    assign wb_idx  = '{ari_val_idx, cmp_val_idx, val_idx_LSB};
    assign wb_val  = '{ari_val, cmp_val, val_LSB};

    assign hd          = ent[head];
    assign rob_full    = (count == CW'(ROB_SIZE));
    assign new_ROB_idx = tail;

    // jp_wrong marks the cycle after a flush: the buffer was just emptied and new traffic is stale
    assign do_alloc   = alloc_flag && !rob_full && !jp_wrong;
    assign do_retire  = hd.busy && hd.ready && !jp_wrong;
    assign hd_jalr    = is_jalr(hd.insty);
    assign hd_branch  = is_branch(hd.insty);
    assign mispredict = hd_jalr || (hd_branch && (hd.value[0] != hd.pred_jump));

    assign query_ready1 = ent[query_idx1].busy && ent[query_idx1].ready;
    assign query_ready2 = ent[query_idx2].busy && ent[query_idx2].ready;
    assign query_val1   = query_ready1 ? ent[query_idx1].value : '0;
    assign query_val2   = query_ready2 ? ent[query_idx2].value : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ROB_SIZE; i++) begin
                ent[i] <= '0;
            end
            head            <= '0;
            tail            <= '0;
            count           <= '0;
            commit_flag     <= 1'b0;
            commit_idx      <= '0;
            commit_rd       <= '0;
            commit_val      <= '0;
            commit_is_store <= 1'b0;
            jp_wrong        <= 1'b0;
            jp_pc           <= '0;
        end else if (!rdy) begin
            commit_flag <= 1'b0;
            jp_wrong    <= 1'b0;
        end else begin
            commit_flag <= do_retire;
            jp_wrong    <= do_retire && mispredict;
            if (do_retire) begin
                commit_idx      <= head;
                commit_rd       <= hd_branch ? 5'd0 : hd.rd;
                commit_is_store <= hd.is_store;
                commit_val      <= hd_jalr ? hd.alt_pc : (hd_branch ? 32'd0 : hd.value);
                if (mispredict) begin
                    jp_pc <= hd_jalr ? {hd.value[31:1], 1'b0} : hd.alt_pc;
                end
            end

            if (!jp_wrong) begin
                for (int c = 0; c < 3; c++) begin
                    if (wb_flag[c] && ent[wb_idx[c]].busy) begin
                        ent[wb_idx[c]].ready <= 1'b1;
                        ent[wb_idx[c]].value <= wb_val[c];
                    end
                end
            end

            if (do_alloc) begin
                ent[tail] <= '{busy: 1'b1, ready: 1'b0, insty: alloc_insty, rd: alloc_rd,
                               is_store: alloc_is_store, pred_jump: alloc_pred_jump,
                               alt_pc: alloc_alt_pc, value: '0};
            end
            if (do_retire) begin
                ent[head].busy <= 1'b0;
            end

            // A flush wins over any allocation or writeback landing on the same edge
            if (do_retire && mispredict) begin
                for (int i = 0; i < ROB_SIZE; i++) begin
                    ent[i].busy  <= 1'b0;
                    ent[i].ready <= 1'b0;
                end
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                head  <= head + IDX_W'(do_retire);
                tail  <= tail + IDX_W'(do_alloc);
                count <= count + CW'(do_alloc) - CW'(do_retire);
            end
        end
    end

endmodule

// File: tb/tb_rob.sv
// tb/tb_rob.sv - randomized scoreboard bench for the reorder buffer against a queue model
module tb_rob;
    import rob_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rdy = 1'b1;
    logic        alloc_flag = 1'b0;
    logic [5:0]  alloc_insty = '0;
    logic [4:0]  alloc_rd = '0;
    logic        alloc_is_store = 1'b0;
    logic        alloc_pred_jump = 1'b0;
    logic [31:0] alloc_alt_pc = '0;
    logic [3:0]  new_ROB_idx;
    logic        rob_full;
    logic [3:0]  query_idx1 = '0, query_idx2 = '0;
    logic        query_ready1, query_ready2;
    logic [31:0] query_val1, query_val2;
    logic        ari_val_flag = 1'b0, cmp_val_flag = 1'b0, val_flag_LSB = 1'b0;
    logic [3:0]  ari_val_idx = '0, cmp_val_idx = '0, val_idx_LSB = '0;
    logic [31:0] ari_val = '0, cmp_val = '0, val_LSB = '0;
    logic        commit_flag;
    logic [3:0]  commit_idx;
    logic [4:0]  commit_rd;
    logic [31:0] commit_val;
    logic        commit_is_store;
    logic        jp_wrong;
    logic [31:0] jp_pc;

    rob #(.ROB_SIZE(16), .IDX_W(4)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .alloc_flag(alloc_flag), .alloc_insty(alloc_insty), .alloc_rd(alloc_rd),
        .alloc_is_store(alloc_is_store), .alloc_pred_jump(alloc_pred_jump),
        .alloc_alt_pc(alloc_alt_pc), .new_ROB_idx(new_ROB_idx), .rob_full(rob_full),
        .query_idx1(query_idx1), .query_idx2(query_idx2),
        .query_ready1(query_ready1), .query_ready2(query_ready2),
        .query_val1(query_val1), .query_val2(query_val2),
        .ari_val_flag(ari_val_flag), .ari_val_idx(ari_val_idx), .ari_val(ari_val),
        .cmp_val_flag(cmp_val_flag), .cmp_val_idx(cmp_val_idx), .cmp_val(cmp_val),
        .val_flag_LSB(val_flag_LSB), .val_idx_LSB(val_idx_LSB), .val_LSB(val_LSB),
        .commit_flag(commit_flag), .commit_idx(commit_idx), .commit_rd(commit_rd),
        .commit_val(commit_val), .commit_is_store(commit_is_store),
        .jp_wrong(jp_wrong), .jp_pc(jp_pc)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          idx;
        logic [5:0]  insty;
        logic [4:0]  rd;
        logic        st;
        logic        pred;
        logic [31:0] alt;
        logic        done;
        logic [31:0] val;
    } ment_t;

    typedef struct {
        int          cyc;
        int          idx;
        logic [4:0]  rd;
        logic [31:0] val;
        logic        st;
        logic        jw;
        logic [31:0] pc;
    } exp_t;

    ment_t mq[$];
    exp_t  sb[$];
    int    m_tail = 0;
    bit    flush_pend = 0;
    int    total = 0;
    int    passed = 0;

    logic        r_rdy = 1'b1;
    logic        a_flag = 1'b0;
    logic [5:0]  a_insty = '0;
    logic [4:0]  a_rd = '0;
    logic        a_st = 1'b0;
    logic        a_pred = 1'b0;
    logic [31:0] a_alt = '0;
    logic        w_flag [3] = '{1'b0, 1'b0, 1'b0};
    logic [3:0]  w_idx  [3] = '{4'd0, 4'd0, 4'd0};
    logic [31:0] w_val  [3] = '{32'd0, 32'd0, 32'd0};

    logic [5:0] ops [12] = '{INST_ADDI, INST_ADDI, INST_ADD, INST_ADD, INST_LW, INST_LW,
                             INST_SW, INST_ADDI, INST_ADD, INST_BEQ, INST_BLTU, INST_JALR};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    function automatic void qexp(input logic [3:0] q, output logic r, output logic [31:0] v);
        r = 1'b0;
        v = '0;
        foreach (mq[k]) if (mq[k].idx == int'(q) && mq[k].done) begin
            r = 1'b1;
            v = mq[k].val;
        end
    endfunction

    task automatic set_alloc(input logic [5:0] op, input logic [4:0] rd, input logic pred,
                             input logic [31:0] alt);
        a_flag = 1'b1; a_insty = op; a_rd = rd; a_st = (op == INST_SW); a_pred = pred; a_alt = alt;
    endtask

    task automatic set_wb(input int c, input logic [3:0] idx, input logic [31:0] v);
        w_flag[c] = 1'b1; w_idx[c] = idx; w_val[c] = v;
    endtask

    // One cycle: check pre-edge state, drive stimulus, advance the model across the edge
    task automatic step();
        bit full, mis, jalr, br;
        exp_t e;
        ment_t h, n;
        logic qr;
        logic [31:0] qv;
        @(negedge clk);
        full = (mq.size() == 16);
        chk("rob_full", rob_full, full);
        chk("new_ROB_idx", new_ROB_idx, m_tail);
        rdy = r_rdy;
        alloc_flag = a_flag; alloc_insty = a_insty; alloc_rd = a_rd;
        alloc_is_store = a_st; alloc_pred_jump = a_pred; alloc_alt_pc = a_alt;
        ari_val_flag = w_flag[0]; ari_val_idx = w_idx[0]; ari_val = w_val[0];
        cmp_val_flag = w_flag[1]; cmp_val_idx = w_idx[1]; cmp_val = w_val[1];
        val_flag_LSB = w_flag[2]; val_idx_LSB = w_idx[2]; val_LSB = w_val[2];
        query_idx1 = 4'($urandom);
        query_idx2 = (mq.size() > 0) ? 4'(mq[$urandom_range(0, mq.size() - 1)].idx) : 4'($urandom);
        #1;
        qexp(query_idx1, qr, qv);
        chk("query_ready1", query_ready1, qr);
        chk("query_val1", query_val1, qv);
        qexp(query_idx2, qr, qv);
        chk("query_ready2", query_ready2, qr);
        chk("query_val2", query_val2, qv);
        mis = 0;
        if (r_rdy) begin
            if (!flush_pend && mq.size() > 0 && mq[0].done) begin
                h = mq.pop_front();
                jalr = (h.insty == INST_JALR);
                br = h.insty inside {INST_BEQ, INST_BNE, INST_BLT, INST_BGE, INST_BLTU, INST_BGEU};
                mis = jalr || (br && (h.val[0] != h.pred));
                e.cyc = cyc + 1;
                e.idx = h.idx;
                e.rd = br ? 5'd0 : h.rd;
                e.st = h.st;
                e.val = jalr ? h.alt : (br ? 32'd0 : h.val);
                e.jw = mis;
                e.pc = jalr ? (h.val & 32'hFFFF_FFFE) : h.alt;
                sb.push_back(e);
            end
            if (!flush_pend) begin
                for (int c = 0; c < 3; c++) begin
                    if (w_flag[c]) begin
                        foreach (mq[k]) if (mq[k].idx == int'(w_idx[c])) begin
                            mq[k].done = 1'b1;
                            mq[k].val = w_val[c];
                        end
                    end
                end
            end
            if (mis) begin
                mq.delete();
                m_tail = 0;
            end else if (a_flag && !full && !flush_pend) begin
                n.idx = m_tail; n.insty = a_insty; n.rd = a_rd; n.st = a_st;
                n.pred = a_pred; n.alt = a_alt; n.done = 1'b0; n.val = '0;
                mq.push_back(n);
                m_tail = (m_tail + 1) % 16;
            end
        end
        flush_pend = mis;
        a_flag = 1'b0;
        for (int c = 0; c < 3; c++) w_flag[c] = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        alloc_flag = 1'b0; ari_val_flag = 1'b0; cmp_val_flag = 1'b0; val_flag_LSB = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        mq.delete();
        sb.delete();
        m_tail = 0;
        flush_pend = 0;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (!rst) begin
                if (commit_flag) begin
                    if (sb.size() == 0) chk("spurious_commit", commit_flag, 1'b0);
                    else begin
                        e = sb.pop_front();
                        chk("commit_cycle", cyc, e.cyc);
                        chk("commit_idx", commit_idx, e.idx);
                        chk("commit_rd", commit_rd, e.rd);
                        chk("commit_val", commit_val, e.val);
                        chk("commit_is_store", commit_is_store, e.st);
                        chk("jp_wrong", jp_wrong, e.jw);
                        if (e.jw) chk("jp_pc", jp_pc, e.pc);
                    end
                end else begin
                    if (jp_wrong) chk("jp_wrong_without_commit", jp_wrong, 1'b0);
                    if (sb.size() > 0 && sb[0].cyc < cyc) begin
                        e = sb.pop_front();
                        chk("commit_flag_missing", commit_flag, 1'b1);
                    end
                end
            end
        end
    end

    initial begin : driver
        repeat (3) @(negedge clk);
        chk("rst_commit_flag", commit_flag, 0);
        chk("rst_commit_idx", commit_idx, 0);
        chk("rst_commit_rd", commit_rd, 0);
        chk("rst_commit_val", commit_val, 0);
        chk("rst_commit_is_store", commit_is_store, 0);
        chk("rst_jp_wrong", jp_wrong, 0);
        chk("rst_jp_pc", jp_pc, 0);
        chk("rst_new_idx", new_ROB_idx, 0);
        chk("rst_rob_full", rob_full, 0);
        chk("rst_query_ready", query_ready1, 0);
        chk("rst_query_val", query_val1, 0);
        rst = 1'b0;

        // simple ALU retire, two edges after the writeback
        set_alloc(INST_ADDI, 5'd7, 1'b0, 32'h0); step();
        set_wb(0, 4'd0, 32'h5); step();
        repeat (3) step();

        // fill to 16, drop a 17th, then retire one and wrap tail
        do_reset();
        for (int i = 0; i < 16; i++) begin set_alloc(INST_ADD, 5'(i + 1), 1'b0, 32'h0); step(); end
        set_alloc(INST_ADD, 5'd20, 1'b0, 32'h0); step();
        set_wb(2, 4'd0, 32'hAA); step();
        step();
        set_alloc(INST_LW, 5'd21, 1'b0, 32'h0); step();
        repeat (3) step();

        // out-of-order completion retires in program order
        do_reset();
        for (int i = 0; i < 3; i++) begin set_alloc(INST_ADDI, 5'(i + 3), 1'b0, 32'h0); step(); end
        set_wb(0, 4'd2, 32'h22); step();
        set_wb(2, 4'd0, 32'h11); step();
        set_wb(1, 4'd1, 32'h33); step();
        repeat (4) step();

        // branch mispredict flushes younger work; allocation during jp_wrong is dropped
        do_reset();
        set_alloc(INST_BEQ, 5'd0, 1'b0, 32'h100); step();
        set_alloc(INST_ADDI, 5'd9, 1'b0, 32'h0); step();
        set_wb(1, 4'd0, 32'h1); step();
        step();
        set_alloc(INST_ADDI, 5'd9, 1'b0, 32'h0); step();
        repeat (3) step();

        // JALR always redirects, links alt_pc
        do_reset();
        set_alloc(INST_JALR, 5'd1, 1'b0, 32'h48); step();
        set_wb(1, 4'd0, 32'h203); step();
        repeat (4) step();

        // three channels in one cycle, then rdy held low with a ready head
        do_reset();
        for (int i = 0; i < 4; i++) begin set_alloc(INST_ADD, 5'(i + 1), 1'b0, 32'h0); step(); end
        set_wb(0, 4'd1, 32'hA1); set_wb(1, 4'd2, 32'hB2); set_wb(2, 4'd3, 32'hC3); step();
        set_wb(0, 4'd0, 32'h90); step();
        r_rdy = 1'b0;
        repeat (3) step();
        r_rdy = 1'b1;
        repeat (6) step();

        for (int s = 0; s < 1200; s++) begin
            if (s == 600) do_reset();
            r_rdy = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 9) < 6)
                set_alloc(ops[$urandom_range(0, 11)], 5'($urandom), 1'($urandom), $urandom);
            for (int c = 0; c < 3; c++) begin
                if ($urandom_range(0, 1) == 1) begin
                    w_idx[c] = (mq.size() > 0 && $urandom_range(0, 3) != 0)
                             ? 4'(mq[$urandom_range(0, mq.size() - 1)].idx) : 4'($urandom);
                    w_val[c] = $urandom;
                    w_flag[c] = 1'b1;
                    for (int d = 0; d < c; d++) if (w_flag[d] && w_idx[d] == w_idx[c]) w_flag[c] = 1'b0;
                end
            end
            step();
        end
        r_rdy = 1'b1;
        repeat (4) step();
        @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
